// File: rtl/fifo_stream_arbiter.sv
// fifo_stream_arbiter: round-robin arbiter sharing one registered fifo write port among NREQ streams.
// Define ARB_BURST_LOCK_EN to arbitrate per packet (grant held until req_last) instead of per beat.
module fifo_stream_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  localparam int SRCW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SRCW-1:0]       out_src,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_t;
  state_t state, state_nxt;
  logic [SRCW-1:0] last_grant, grant;
  logic found, load, accept, ends_unit, lock;
  assign lock = state == LOCKED;
  assign load = !out_valid | out_ready;
  assign accept = resetn & load & found;
  assign req_ready = accept ? NREQ'(1) << grant : '0;
  assign busy = out_valid | lock;
`ifdef ARB_BURST_LOCK_EN
  assign ends_unit = req_last[grant];
`else
  assign ends_unit = 1'b1;
`endif
  // Scan farthest-to-nearest so the nearest valid requester after last_grant wins.
  // While locked, out_src still holds the lock owner since only it can be accepted.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant) + k) % NREQ]) begin
        grant = SRCW'((int'(last_grant) + k) % NREQ);
        found = 1'b1;
      end
    end
    if (lock) begin
      grant = out_src;
      found = req_valid[out_src];
    end
  end
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = ends_unit ? HOLD : LOCKED;
    else if (state == HOLD && out_ready) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      out_last <= 1'b0;
      last_grant <= SRCW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= req_data[int'(grant)*WIDTH +: WIDTH];
        out_src <= grant;
        out_last <= req_last[grant];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && ends_unit) last_grant <= grant;
    end
  end
endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// tb_fifo_stream_arbiter: directed and randomized checks of fifo_stream_arbiter against a behavioural model.
module tb_fifo_stream_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 32;
`ifdef ARB_BURST_LOCK_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0] out_src;
  logic out_last, out_valid, busy;
  logic out_ready = 1'b0;
  int n_cmp = 0, n_err = 0;
  bit m_ov, m_last, m_lock;
  logic [WIDTH-1:0] m_data;
  int m_src, m_lg, m_lidx;

  fifo_stream_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Grant = valid requester at the smallest round-robin distance after the last winner.
  function automatic int m_grant();
    int best = -1;
    int bd = NREQ;
    if (m_lock) return req_valid[m_lidx] ? m_lidx : -1;
    for (int i = 0; i < NREQ; i++) begin
      int d;
      d = (i - m_lg - 1 + 2*NREQ) % NREQ;
      if (req_valid[i] && d < bd) begin
        bd = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int g;
    g = m_grant();
    if (!resetn || (m_ov && !out_ready) || g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  task automatic tick();
    int g;
    @(posedge clk);
    g = (resetn && (!m_ov || out_ready)) ? m_grant() : -1;
    if (!resetn) begin
      m_ov = 0; m_data = '0; m_src = 0; m_last = 0; m_lock = 0; m_lg = NREQ-1; m_lidx = 0;
    end else if (g >= 0) begin
      m_ov = 1;
      m_data = req_data[g*WIDTH +: WIDTH];
      m_src = g;
      m_last = req_last[g];
      if (!BURST || req_last[g]) begin
        m_lg = g;
        m_lock = 0;
      end else begin
        m_lock = 1;
        m_lidx = g;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 0;
    req_valid = '0;
    tick();
    tick();
    resetn = 1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    resetn = 0;
    req_valid = '1;
    req_last = '1;
    out_ready = 1;
    for (int i = 0; i < NREQ; i++) set_data(i, 32'h1000_0000 * i + 32'h55);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_ready: got %b expected 0000", req_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_src !== 2'd0 || out_last !== 1'b0) begin
        n_err++;
        $display("FAIL reset_out: got valid=%b busy=%b data=%h src=%0d last=%b expected all zero",
                 out_valid, busy, out_data, out_src, out_last);
      end
    end
    resetn = 1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'h55) begin
      n_err++;
      $display("FAIL reset_first_beat: got valid=%b src=%0d data=%h expected 1 0 00000055", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_rr();
    do_reset();
    req_valid = '1;
    req_last = '1;
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (out_src !== 2'(k % 4) || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rr_seq[%0d]: got src=%0d valid=%b expected src=%0d valid=1", k, out_src, out_valid, k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    do_reset();
    out_ready = 0;
    req_last = '1;
    req_valid = 4'b0001;
    set_data(0, 32'hA5A5_A5A5);
    set_data(1, 32'h1111_1111);
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1 a5a5a5a5", c, out_valid, out_data);
      end
    end
    req_valid = '0;
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid && out_ready && out_data == 32'hA5A5_A5A5) cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 1) begin
      n_err++;
      $display("FAIL bp_transfers: got %0d expected 1", cnt);
    end
  endtask

  task automatic test_wrap();
    int exp_w[3] = '{1, 3, 1};
    do_reset();
    out_ready = 1;
    req_last = '1;
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (out_src !== 2'(exp_w[k]) || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL wrap[%0d]: got src=%0d valid=%b expected %0d 1", k, out_src, out_valid, exp_w[k]);
      end
    end
  endtask

  task automatic test_burst();
    int got[$];
    int exp_b[5];
    int b = 0;
    bit acc, acc0;
    exp_b = BURST ? '{0, 0, 0, 0, 2} : '{0, 2, 0, 2, 0};
    do_reset();
    out_ready = 1;
    set_data(2, 32'h2222_0000);
    for (int c = 0; c < 7; c++) begin
      req_valid[0] = (b < 4) && (c != 3);
      req_valid[2] = 1;
      req_last[0] = (b == 3);
      req_last[2] = 1;
      set_data(0, 32'h0B00 + b);
      #1;
      acc0 = req_ready[0];
      acc = |(req_ready & req_valid);
`ifdef ARB_BURST_LOCK_EN
      if (c == 3) begin
        n_cmp++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL burst_gap_stall: got ready=%b busy=%b expected 0000 1", req_ready, busy);
        end
      end
`endif
      tick();
      if (acc) got.push_back(int'(out_src));
      if (acc0) begin
        n_cmp++;
        if (out_data !== 32'h0B00 + b) begin
          n_err++;
          $display("FAIL burst_data[%0d]: got %h expected %h", b, out_data, 32'h0B00 + b);
        end
        b++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (got.size() <= k) begin
        n_err++;
        $display("FAIL burst_seq[%0d]: got no beat expected src=%0d", k, exp_b[k]);
      end else if (got[k] != exp_b[k]) begin
        n_err++;
        $display("FAIL burst_seq[%0d]: got src=%0d expected %0d", k, got[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    out_ready = 0;
    req_valid = 4'b0001;
    req_last = 4'b0000;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: got valid=%b busy=%b expected 1 1", out_valid, busy);
    end
    resetn = 0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    resetn = 1;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    out_ready = 1;
    tick();
    n_cmp++;
    if (out_src !== 2'd0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_first: got src=%0d valid=%b expected 0 1", out_src, out_valid);
    end
    tick();
    n_cmp++;
    if (out_src !== 2'd1) begin
      n_err++;
      $display("FAIL mid_second: got src=%0d expected 1", out_src);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_last = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      resetn = ($urandom_range(49) != 0);
      for (int i = 0; i < NREQ; i++) set_data(i, $urandom);
      #1;
      exp_r = m_ready();
      n_cmp++;
      if (req_ready !== exp_r) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_r);
      end
      tick();
      n_cmp++;
      if (out_valid !== m_ov || busy !== (m_ov | m_lock)) begin
        n_err++;
        $display("FAIL rand_state[%0d]: got valid=%b busy=%b expected %b %b", c, out_valid, busy, m_ov, m_ov | m_lock);
      end
      if (m_ov) begin
        n_cmp++;
        if (out_data !== m_data || out_src !== 2'(m_src) || out_last !== m_last) begin
          n_err++;
          $display("FAIL rand_beat[%0d]: got %h/%0d/%b expected %h/%0d/%b",
                   c, out_data, out_src, out_last, m_data, m_src, m_last);
        end
      end
    end
    resetn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_ov = 0; m_data = '0; m_src = 0; m_last = 0; m_lock = 0; m_lg = NREQ-1; m_lidx = 0;
    test_reset();
    test_rr();
    test_backpressure();
    test_wrap();
    test_burst();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
